// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use interlock, EXE jump
// flush, and IF/MEM arbitration of the shared SRAM with a wait-state sequencer.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | no data access in flight; IF owns SRAM unless MEM requests now
// MEM_BUSY | data access in flight; cnt counts hold cycles left before release
module pipe_hazard_ctrl #(
  parameter int         RAM_WAIT = 1,
  parameter int         CNT_W    = 4,
  parameter logic [3:0] REG_NONE = 4'hF
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic [3:0]  id_REG_A,
  input  logic [3:0]  id_REG_B,
  input  logic        id_USE_A,
  input  logic        id_USE_B,
  input  logic        ie_RAM_EN,
  input  logic        ie_RAM_op,
  input  logic [3:0]  ie_WB_REG,
  input  logic        ie_JUMP_TAKEN,
  input  logic        em_RAM_REQ,
  output logic        pc_PAUSE,
  output logic        ii_PAUSE,
  output logic        ii_FLUSH,
  output logic        ie_PAUSE,
  output logic        ie_FLUSH,
  output logic        em_PAUSE,
  output logic        ram_SEL,
  output logic [15:0] stall_CNT
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_BUSY = 1'b1
  } state_t;

  // The request cycle is itself a hold cycle, so the counter starts two short.
  localparam logic [CNT_W-1:0] CNT_INIT = (RAM_WAIT > 1) ? CNT_W'(RAM_WAIT - 2) : '0;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hold, release_cyc, load_use;

  assign load_use = ie_RAM_EN & ~ie_RAM_op & (ie_WB_REG != REG_NONE) &
                    ((id_USE_A & (id_REG_A == ie_WB_REG)) |
                     (id_USE_B & (id_REG_B == ie_WB_REG)));

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_CNT <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_nxt;
      if (pc_PAUSE && (stall_CNT != 16'hFFFF))
        stall_CNT <= stall_CNT + 16'd1;
    end
  end

  always_comb begin
    next_state  = state;
    cnt_nxt     = cnt;
    hold        = 1'b0;
    release_cyc = 1'b0;
    pc_PAUSE    = 1'b0;
    ii_PAUSE    = 1'b0;
    ii_FLUSH    = 1'b0;
    ie_PAUSE    = 1'b0;
    ie_FLUSH    = 1'b0;
    em_PAUSE    = 1'b0;
    ram_SEL     = 1'b0;

    if (!rst) begin
      ii_FLUSH = 1'b1;
      ie_FLUSH = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (em_RAM_REQ) begin
            if (RAM_WAIT > 1) begin
              hold       = 1'b1;
              next_state = MEM_BUSY;
              cnt_nxt    = CNT_INIT;
            end else begin
              release_cyc = 1'b1;
            end
          end
        end
        MEM_BUSY: begin
          if (cnt != '0) begin
            hold    = 1'b1;
            cnt_nxt = cnt - 1'b1;
          end else begin
            release_cyc = 1'b1;
            next_state  = RUN;
          end
        end
        default: next_state = RUN;
      endcase

      ram_SEL = hold | release_cyc;

      // Jump and load-use wait out hold cycles; frozen ID/EXE re-present them.
      if (hold) begin
        pc_PAUSE = 1'b1;
        ii_PAUSE = 1'b1;
        ie_PAUSE = 1'b1;
        em_PAUSE = 1'b1;
      end else if (ie_JUMP_TAKEN) begin
        ii_FLUSH = 1'b1;
        ie_FLUSH = 1'b1;
      end else if (load_use) begin
        pc_PAUSE = 1'b1;
        ii_PAUSE = 1'b1;
        ie_FLUSH = 1'b1;
      end else if (release_cyc) begin
        pc_PAUSE = 1'b1;
        ii_FLUSH = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: RAM_WAIT=3 and RAM_WAIT=1 instances share stimulus
// and are compared against a countdown-of-access-cycles reference model.
module tb_pipe_hazard_ctrl;

  logic       clk_50MHz = 1'b0;
  logic       rst;
  logic [3:0] id_REG_A, id_REG_B, ie_WB_REG;
  logic       id_USE_A, id_USE_B, ie_RAM_EN, ie_RAM_op, ie_JUMP_TAKEN, em_RAM_REQ;

  // {pc_PAUSE, ii_PAUSE, ii_FLUSH, ie_PAUSE, ie_FLUSH, em_PAUSE, ram_SEL}
  wire logic [6:0]  o3, o1;
  wire logic [15:0] s3, s1;

  int vectors = 0;
  int miscompares = 0;
  int left3 = 0, left1 = 0;
  int cnt3 = 0, cnt1 = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  pipe_hazard_ctrl #(.RAM_WAIT(3)) dut3 (
    .clk_50MHz(clk_50MHz), .rst(rst),
    .id_REG_A(id_REG_A), .id_REG_B(id_REG_B), .id_USE_A(id_USE_A), .id_USE_B(id_USE_B),
    .ie_RAM_EN(ie_RAM_EN), .ie_RAM_op(ie_RAM_op), .ie_WB_REG(ie_WB_REG),
    .ie_JUMP_TAKEN(ie_JUMP_TAKEN), .em_RAM_REQ(em_RAM_REQ),
    .pc_PAUSE(o3[6]), .ii_PAUSE(o3[5]), .ii_FLUSH(o3[4]), .ie_PAUSE(o3[3]),
    .ie_FLUSH(o3[2]), .em_PAUSE(o3[1]), .ram_SEL(o3[0]), .stall_CNT(s3)
  );

  pipe_hazard_ctrl #(.RAM_WAIT(1)) dut1 (
    .clk_50MHz(clk_50MHz), .rst(rst),
    .id_REG_A(id_REG_A), .id_REG_B(id_REG_B), .id_USE_A(id_USE_A), .id_USE_B(id_USE_B),
    .ie_RAM_EN(ie_RAM_EN), .ie_RAM_op(ie_RAM_op), .ie_WB_REG(ie_WB_REG),
    .ie_JUMP_TAKEN(ie_JUMP_TAKEN), .em_RAM_REQ(em_RAM_REQ),
    .pc_PAUSE(o1[6]), .ii_PAUSE(o1[5]), .ii_FLUSH(o1[4]), .ie_PAUSE(o1[3]),
    .ie_FLUSH(o1[2]), .em_PAUSE(o1[1]), .ram_SEL(o1[0]), .stall_CNT(s1)
  );

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Model: 'left' is the number of access cycles still owed by MEM (0 = idle).
  task automatic model(input int w, input int left, output logic [6:0] o, output int nleft);
    int  cur;
    bit  lu;
    lu = ie_RAM_EN && !ie_RAM_op && (ie_WB_REG != 4'hF) &&
         ((id_USE_A && id_REG_A == ie_WB_REG) || (id_USE_B && id_REG_B == ie_WB_REG));
    if (!rst) begin
      o = 7'b0010100;
      nleft = 0;
    end else begin
      cur = (left > 0) ? left : (em_RAM_REQ ? w : 0);
      if (cur > 1)            o = 7'b1101011;
      else if (ie_JUMP_TAKEN) o = {6'b001010, cur == 1};
      else if (lu)            o = {6'b110010, cur == 1};
      else if (cur == 1)      o = 7'b1010001;
      else                    o = 7'b0000000;
      nleft = (cur > 0) ? cur - 1 : 0;
    end
  endtask

  function automatic int next_cnt(int c, logic pc_pause);
    if (!rst) return 0;
    if (pc_pause && c < 65535) return c + 1;
    return c;
  endfunction

  task automatic step();
    logic [6:0] e3, e1;
    int n3, n1;
    #2;
    model(3, left3, e3, n3);
    model(1, left1, e1, n1);
    check("ctrl_w3", {9'd0, o3}, {9'd0, e3});
    check("ctrl_w1", {9'd0, o1}, {9'd0, e1});
    @(posedge clk_50MHz);
    left3 = n3;
    left1 = n1;
    cnt3  = next_cnt(cnt3, e3[6]);
    cnt1  = next_cnt(cnt1, e1[6]);
    #1;
    check("stall_w3", s3, 16'(cnt3));
    check("stall_w1", s1, 16'(cnt1));
  endtask

  task automatic idle_inputs();
    id_REG_A = 4'd0; id_REG_B = 4'd0; id_USE_A = 0; id_USE_B = 0;
    ie_RAM_EN = 0; ie_RAM_op = 0; ie_WB_REG = 4'hF;
    ie_JUMP_TAKEN = 0; em_RAM_REQ = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    step();
    rst = 1;
  endtask

  task automatic set_load_use();
    ie_RAM_EN = 1; ie_RAM_op = 0; ie_WB_REG = 4'd3;
    id_REG_A = 4'd3; id_USE_A = 1;
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    #1;
    check("reset_ctrl", {9'd0, o3}, 16'h0014);
    step();
    check("reset_stall", s3, 16'h0000);
    rst = 1;

    // load-use on RAM_WAIT=1
    set_load_use();
    #1 check("lu_ctrl", {9'd0, o1}, 16'h0064);
    step();
    ie_WB_REG = 4'hF; ie_RAM_EN = 0;
    #1 check("lu_clear", {9'd0, o1}, 16'h0000);
    step();
    check("lu_stall", s1, 16'd1);

    // no stall when operand unused or destination is REG_NONE
    do_reset();
    set_load_use(); id_USE_A = 0;
    #1 check("lu_unused", {9'd0, o1}, 16'h0000);
    step();
    set_load_use(); ie_WB_REG = 4'hF; id_REG_A = 4'hF;
    #1 check("lu_none", {9'd0, o1}, 16'h0000);
    step();

    // RAM_WAIT=3 access: 2 hold, 1 release
    idle_inputs(); do_reset();
    em_RAM_REQ = 1;
    #1 check("acc_hold0", {9'd0, o3}, 16'h006B);
    step();
    #1 check("acc_hold1", {9'd0, o3}, 16'h006B);
    step();
    em_RAM_REQ = 0;
    #1 check("acc_rel", {9'd0, o3}, 16'h0051);
    step();
    #1 check("acc_idle", {9'd0, o3}, 16'h0000);
    step();
    check("acc_stall", s3, 16'd3);

    // jump during access
    do_reset();
    em_RAM_REQ = 1; step();
    ie_JUMP_TAKEN = 1;
    #1 check("jmp_hold", {9'd0, o3}, 16'h006B);
    step();
    #1 check("jmp_rel", {9'd0, o3}, 16'h0015);
    step();

    // release coinciding with load-use
    idle_inputs(); do_reset();
    em_RAM_REQ = 1; step(); step();
    set_load_use();
    #1 check("lu_rel", {9'd0, o3}, 16'h0065);
    step();

    // reset mid-access (cnt=1)
    idle_inputs(); do_reset();
    em_RAM_REQ = 1; step();
    rst = 0; em_RAM_REQ = 0;
    #1 check("mid_rst_ctrl", {9'd0, o3}, 16'h0014);
    step();
    rst = 1;
    #1 check("mid_rst_sel", {15'd0, o3[0]}, 16'd0);
    check("mid_rst_stall", s3, 16'd0);
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 49) != 0);
      id_REG_A      = 4'($urandom_range(3, 5));
      id_REG_B      = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(3, 5));
      id_USE_A      = 1'($urandom);
      id_USE_B      = 1'($urandom);
      ie_RAM_EN     = 1'($urandom);
      ie_RAM_op     = ($urandom_range(0, 3) == 0);
      ie_WB_REG     = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(3, 5));
      ie_JUMP_TAKEN = ($urandom_range(0, 4) == 0);
      em_RAM_REQ    = ($urandom_range(0, 2) == 0);
      step();
    end

    // continuous stall drives stall_CNT into saturation
    idle_inputs(); do_reset();
    em_RAM_REQ = 1;
    for (int i = 0; i < 65540; i++) step();
    check("sat_w3", s3, 16'hFFFF);
    check("sat_w1", s1, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage 16-bit pipeline. It drives the PAUSE/FLUSH controls of the PC, IF/ID, ID/EXE and EXE/MEM registers. It detects load-use hazards and taken jumps resolved in EXE. It also arbitrates the single shared SRAM between instruction fetch and MEM-stage data access, sequencing multi-cycle data accesses with a wait-state FSM.

Parameters:
RAM_WAIT, 1, cycles the SRAM is owned by MEM per data access (legal 1..15)
CNT_W, 4, width of wait-state counter
REG_NONE, 4'hF, unified register id meaning "no register"

Ports:
clk_50MHz  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-low reset
id_REG_A  in  4  unified id of first source read in ID (0-7 R0-R7, 8 SP, 9 IH, A RA, B T)
id_REG_B  in  4  unified id of second source read in ID
id_USE_A  in  1  ID instruction actually reads id_REG_A
id_USE_B  in  1  ID instruction actually reads id_REG_B
ie_RAM_EN  in  1  instruction in EXE accesses RAM
ie_RAM_op  in  1  0 = read (load), 1 = write
ie_WB_REG  in  4  unified destination id of EXE instruction (REG_NONE if none)
ie_JUMP_TAKEN  in  1  EXE resolved a taken branch/jump this cycle
em_RAM_REQ  in  1  MEM-stage instruction needs the shared SRAM
pc_PAUSE  out  1  hold PC
ii_PAUSE  out  1  hold IF/ID
ii_FLUSH  out  1  load NOP into IF/ID
ie_PAUSE  out  1  hold ID/EXE
ie_FLUSH  out  1  load NOP (bubble) into ID/EXE
em_PAUSE  out  1  hold EXE/MEM
ram_SEL  out  1  SRAM owner: 0 = IF, 1 = MEM
stall_CNT  out  16  saturating count of cycles with pc_PAUSE=1

Behaviour:
- State: FSM {RUN, MEM_BUSY}, counter cnt[CNT_W-1:0], stall_CNT. Control outputs are combinational from state and inputs, so they act on the same edge.
- Reset: while rst=0, ii_FLUSH=ie_FLUSH=1 and all PAUSE=0, ram_SEL=0. On the edge, state<=RUN, cnt<=0, stall_CNT<=0. Reset mid-access abandons the access.
- Load-use condition LU: ie_RAM_EN & ~ie_RAM_op & ie_WB_REG!=REG_NONE & ((id_USE_A & id_REG_A==ie_WB_REG) | (id_USE_B & id_REG_B==ie_WB_REG)).
- Data access, RAM_WAIT cycles starting the first cycle em_RAM_REQ=1 in RUN. ram_SEL=1 for all RAM_WAIT cycles.
  - Hold cycles (first RAM_WAIT-1): pc_PAUSE=ii_PAUSE=ie_PAUSE=em_PAUSE=1, no flushes.
  - Release cycle (last): em_PAUSE=ie_PAUSE=0, pc_PAUSE=1, ii_FLUSH=1 (the fetch slot was lost).
- FSM transitions:
  - RUN & em_RAM_REQ & RAM_WAIT>1: go to MEM_BUSY, cnt<=RAM_WAIT-2. That first cycle is a hold cycle.
  - MEM_BUSY & cnt!=0: stay, cnt<=cnt-1, hold cycle.
  - MEM_BUSY & cnt==0: release cycle, go to RUN.
  - RAM_WAIT=1: the request cycle is itself the release cycle; stay in RUN.
  - em_RAM_REQ is ignored in MEM_BUSY; it is guaranteed held by em_PAUSE.
  - Back-to-back accesses: a new request starts the cycle after release.
- Priority in any non-hold cycle:
  1. ie_JUMP_TAKEN: ii_FLUSH=1, ie_FLUSH=1, pc_PAUSE=0 (PC loads target, overriding release-cycle pc_PAUSE), ii_PAUSE=0. LU is ignored.
  2. LU: pc_PAUSE=1, ii_PAUSE=1, ie_FLUSH=1. ii_PAUSE overrides release-cycle ii_FLUSH, so ii_FLUSH=0.
  3. Release cycle alone: as above.
  4. Otherwise all PAUSE/FLUSH = 0, ram_SEL=0.
- During hold cycles, jump and LU are not acted on. EXE/ID are frozen, so the conditions re-present at release.
- LU needs no state: after one bubble, EXE no longer holds the load, so LU clears.
- stall_CNT increments each cycle with pc_PAUSE=1 (rst high) and saturates at 16'hFFFF.

Test Plan:
- Load R3 in EXE (ie_RAM_EN=1, op=0, WB=3); ID reads A=3, USE_A=1, RAM_WAIT=1 -> one cycle pc_PAUSE=ii_PAUSE=ie_FLUSH=1, then all 0; stall_CNT=1.
- Same load, but ID reads A=3 with USE_A=0, or WB=REG_NONE -> no stall.
- RAM_WAIT=3, em_RAM_REQ=1 -> 2 hold cycles (all four PAUSE=1, ram_SEL=1), then 1 release cycle (pc_PAUSE=ii_FLUSH=1, ram_SEL=1), then ram_SEL=0; stall_CNT=3.
- RAM_WAIT=3, ie_JUMP_TAKEN=1 during the access -> hold cycles unchanged; release cycle gives pc_PAUSE=0, ii_FLUSH=ie_FLUSH=1.
- Release cycle coinciding with LU -> pc_PAUSE=ii_PAUSE=ie_FLUSH=1, ii_FLUSH=0.
- rst=0 asserted mid-MEM_BUSY (cnt=1) -> next cycle state RUN, ram_SEL=0, stall_CNT=0; preset stall_CNT=16'hFFFE with continuous stall -> holds at 16'hFFFF.
